// File: rtl/mac_header_filter.sv
// Classifies each received MAC header as keep/drop and queues the decision, plus a
// src/dst-swapped reply header for every kept frame, in two order-aligned FIFOs.
module mac_header_filter #(
    parameter int unsigned HEADER_WIDTH     = 112,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter logic [47:0] FPGA_MAC         = 48'h001C24174ACB,
    parameter bit          ACCEPT_BROADCAST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [HEADER_WIDTH-1:0] header_data,
    input  logic                    header_valid,
    output logic                    drop,
    output logic                    drop_vld,
    input  logic                    drop_ack,
    output logic [HEADER_WIDTH-1:0] reply_hdr,
    output logic                    reply_hdr_vld,
    input  logic                    reply_hdr_rdy,
    output logic [15:0]             rx_cnt,
    output logic [15:0]             drop_cnt,
    output logic                    overflow
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned BODY  = HEADER_WIDTH - 48;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    // Stage register: src + ethertype plus the keep decision made on dst.
    logic            stg_valid;
    logic            stg_keep;
    logic [BODY-1:0] stg_body;
    logic [47:0]     dst_in;
    logic            keep_in;

    assign dst_in  = header_data[HEADER_WIDTH-1 -: 48];
    assign keep_in = (dst_in == FPGA_MAC) || (ACCEPT_BROADCAST && (dst_in == BCAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= 1'b0;
            stg_keep  <= 1'b0;
            stg_body  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            stg_valid <= header_valid;
            if (header_valid) begin
                stg_keep <= keep_in;
                stg_body <= header_data[BODY-1:0];
            end
        end
    end

    logic                    dec_mem [FIFO_DEPTH];
    logic [HEADER_WIDTH-1:0] rep_mem [FIFO_DEPTH];
    logic [AW:0]             dec_wr, dec_rd, rep_wr, rep_rd;
    logic                    dec_empty, dec_full, rep_empty, rep_full;
    logic                    dec_pop, rep_pop, lost, dec_push, rep_push;
    logic [HEADER_WIDTH-1:0] reply_word;

    assign dec_empty = (dec_wr == dec_rd);
    assign dec_full  = (dec_wr[AW] != dec_rd[AW]) && (dec_wr[AW-1:0] == dec_rd[AW-1:0]);
    assign rep_empty = (rep_wr == rep_rd);
    assign rep_full  = (rep_wr[AW] != rep_rd[AW]) && (rep_wr[AW-1:0] == rep_rd[AW-1:0]);

    assign dec_pop = drop_ack && !dec_empty;
    assign rep_pop = reply_hdr_rdy && !rep_empty;

    // A header is discarded as a whole so the decision and reply queues never misalign.
    assign lost     = stg_valid && ((dec_full && !dec_pop) || (stg_keep && rep_full && !rep_pop));
    assign dec_push = stg_valid && !lost;
    assign rep_push = dec_push && stg_keep;

    assign reply_word = {stg_body[BODY-1 -: 48], FPGA_MAC, stg_body[BODY-49:0]};

    // NOTE: FIFO storage has no reset; pointers define validity and outputs are gated when empty.
    always_ff @(posedge clk) begin
        if (dec_push) dec_mem[dec_wr[AW-1:0]] <= !stg_keep;
        if (rep_push) rep_mem[rep_wr[AW-1:0]] <= reply_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_wr   <= '0;
            dec_rd   <= '0;
            rep_wr   <= '0;
            rep_rd   <= '0;
            rx_cnt   <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (dec_push) dec_wr <= dec_wr + 1'b1;
            if (dec_pop)  dec_rd <= dec_rd + 1'b1;
            if (rep_push) rep_wr <= rep_wr + 1'b1;
            if (rep_pop)  rep_rd <= rep_rd + 1'b1;
            if (stg_valid && rx_cnt != 16'hFFFF) rx_cnt <= rx_cnt + 16'd1;
            if (dec_push && !stg_keep && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (lost) overflow <= 1'b1;
        end
    end

    assign drop_vld      = !dec_empty;
    assign drop          = !dec_empty && dec_mem[dec_rd[AW-1:0]];
    assign reply_hdr_vld = !rep_empty;
    assign reply_hdr     = rep_empty ? '0 : rep_mem[rep_rd[AW-1:0]];

endmodule
